// File: rtl/flappy_pkg.sv
// Shared constants and state encoding for the bird motion block.
// Screen rows are 10-bit unsigned (row 0 is the top); velocities are small unsigned magnitudes.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  localparam logic [9:0] Y_TOP    = 10'd0;
  localparam logic [9:0] Y_GROUND = 10'd464;
  localparam logic [9:0] Y_START  = 10'd240;
  localparam logic [5:0] FLAP_V   = 6'd12;
  localparam logic [5:0] GRAV     = 6'd1;
  localparam logic [5:0] V_MAX    = 6'd15;

endpackage

// File: rtl/bird_phys_next.sv
// Combinational next-position/velocity step for one flap or gravity tick.
// With no tick the current position and velocity pass through unchanged.
module bird_phys_next
  import flappy_pkg::*;
(
  input  logic              [9:0] bird_y,
  input  logic signed       [6:0] bird_vel,
  input  logic                    up,
  input  logic                    down,
  output logic              [9:0] y_next,
  output logic signed       [6:0] v_next,
  output logic                    hit_ground
);

  localparam logic signed [6:0]  V_UP   = -$signed({1'b0, FLAP_V});
  localparam logic signed [7:0]  GRAV8  = $signed({2'b00, GRAV});
  localparam logic signed [7:0]  VMAX8  = $signed({2'b00, V_MAX});
  localparam logic signed [10:0] TOP11  = $signed({1'b0, Y_TOP});
  localparam logic signed [10:0] GND11  = $signed({1'b0, Y_GROUND});

  logic signed [7:0]  w_vel_inc;
  logic signed [6:0]  w_v_cand;
  logic signed [10:0] w_y_sum;

  // One extra bit on the increment so saturation is decided before any wrap.
  assign w_vel_inc = $signed({bird_vel[6], bird_vel}) + GRAV8;

  always_comb begin
    w_v_cand = bird_vel;
    if (up) begin
      w_v_cand = V_UP;
    end else if (down) begin
      w_v_cand = (w_vel_inc > VMAX8) ? VMAX8[6:0] : w_vel_inc[6:0];
    end
  end

  assign w_y_sum = $signed({1'b0, bird_y}) + $signed({{4{w_v_cand[6]}}, w_v_cand});

  always_comb begin
    y_next     = bird_y;
    v_next     = bird_vel;
    hit_ground = 1'b0;
    if (up || down) begin
      if (w_y_sum <= TOP11) begin
        y_next = Y_TOP;
        v_next = '0;
      end else if (w_y_sum >= GND11) begin
        y_next     = Y_GROUND;
        v_next     = '0;
        hit_ground = 1'b1;
      end else begin
        y_next = w_y_sum[9:0];
        v_next = w_v_cand;
      end
    end
  end

endmodule

// File: rtl/bird_motion.sv
// Round state machine (IDLE/PLAY/DEAD) plus registered bird position and velocity.
// Ticks act only in PLAY; a pipe hit freezes the bird where it is.
module bird_motion
  import flappy_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              up_key_press,
  input  logic              down_key_press,
  input  logic              hit,
  output logic        [9:0] bird_y,
  output logic signed [6:0] bird_vel,
  output logic              playing,
  output logic              game_over,
  output state_t            dbg_state
);

  state_t             r_state;
  logic         [9:0] r_y;
  logic signed  [6:0] r_vel;
  logic               r_playing;
  logic               r_game_over;

  state_t             w_state_nxt;
  logic         [9:0] w_y_nxt;
  logic signed  [6:0] w_vel_nxt;
  logic         [9:0] w_phys_y;
  logic signed  [6:0] w_phys_v;
  logic               w_hit_ground;

  bird_phys_next u_phys (
    .bird_y     (r_y),
    .bird_vel   (r_vel),
    .up         (up_key_press),
    .down       (down_key_press),
    .y_next     (w_phys_y),
    .v_next     (w_phys_v),
    .hit_ground (w_hit_ground)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_vel_nxt   = r_vel;
    case (r_state)
      ST_IDLE: begin
        w_y_nxt   = Y_START;
        w_vel_nxt = '0;
        if (start) w_state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        // A pipe hit outranks any tick in the same cycle.
        if (hit) begin
          w_state_nxt = ST_DEAD;
        end else begin
          w_y_nxt   = w_phys_y;
          w_vel_nxt = w_phys_v;
          if (w_hit_ground) w_state_nxt = ST_DEAD;
        end
      end
      ST_DEAD: begin
        if (start) begin
          w_state_nxt = ST_IDLE;
          w_y_nxt     = Y_START;
          w_vel_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_y_nxt     = Y_START;
        w_vel_nxt   = '0;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with bird_y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_y         <= Y_START;
      r_vel       <= '0;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_y         <= w_y_nxt;
      r_vel       <= w_vel_nxt;
      r_playing   <= (w_state_nxt == ST_PLAY);
      r_game_over <= (w_state_nxt == ST_DEAD);
    end
  end

  assign bird_y    = r_y;
  assign bird_vel  = r_vel;
  assign playing   = r_playing;
  assign game_over = r_game_over;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bird_motion.sv
// Self-checking bench for bird_motion: fixed vector table, hand-built corner
// sequences and random ticks compared against an integer reference model.
module tb_bird_motion;
  import flappy_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              up_key_press;
  logic              down_key_press;
  logic              hit;
  logic        [9:0] bird_y;
  logic signed [6:0] bird_vel;
  logic              playing;
  logic              game_over;
  state_t            dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 0 = idle, 1 = play, 2 = dead; plain integer arithmetic.
  int m_state, m_y, m_v;

  bird_motion dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .up_key_press   (up_key_press),
    .down_key_press (down_key_press),
    .hit            (hit),
    .bird_y         (bird_y),
    .bird_vel       (bird_vel),
    .playing        (playing),
    .game_over      (game_over),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit s, u, d, h;
    int y, v;
    bit p, g;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_y     = 240;
    m_v     = 0;
  endtask

  task automatic model_step(input bit s, input bit u, input bit d, input bit h);
    int nv, ny;
    case (m_state)
      0: begin
        m_y = 240;
        m_v = 0;
        if (s) m_state = 1;
      end
      1: begin
        if (h) begin
          m_state = 2;
        end else if (u || d) begin
          if (u) nv = -12;
          else   nv = (m_v + 1 > 15) ? 15 : m_v + 1;
          ny = m_y + nv;
          if (ny <= 0) begin
            m_y = 0;
            m_v = 0;
          end else if (ny >= 464) begin
            m_y = 464;
            m_v = 0;
            m_state = 2;
          end else begin
            m_y = ny;
            m_v = nv;
          end
        end
      end
      default: begin
        if (s) begin
          m_state = 0;
          m_y = 240;
          m_v = 0;
        end
      end
    endcase
  endtask

  task automatic drive_cycle(input bit s, input bit u, input bit d, input bit h);
    start          = s;
    up_key_press   = u;
    down_key_press = d;
    hit            = h;
    @(posedge clk);
    model_step(s, u, d, h);
    #1;
    start = 1'b0; up_key_press = 1'b0; down_key_press = 1'b0; hit = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".y"},   int'(bird_y), m_y);
    check({tag, ".vel"}, int'(bird_vel), m_v);
    check({tag, ".playing"},   int'(playing),   (m_state == 1) ? 1 : 0);
    check({tag, ".game_over"}, int'(game_over), (m_state == 2) ? 1 : 0);
  endtask

  task automatic set_vec(input int i, input bit s, input bit u, input bit d, input bit h,
                         input int y, input int v, input bit p, input bit g);
    tbl[i].s = s; tbl[i].u = u; tbl[i].d = d; tbl[i].h = h;
    tbl[i].y = y; tbl[i].v = v; tbl[i].p = p; tbl[i].g = g;
  endtask

  initial begin
    //       #   s  u  d  h    y    v  p  g
    set_vec( 0, 0, 0, 0, 0, 240,   0, 0, 0);
    set_vec( 1, 1, 0, 0, 0, 240,   0, 1, 0);
    set_vec( 2, 0, 0, 1, 0, 241,   1, 1, 0);
    set_vec( 3, 0, 0, 1, 0, 243,   2, 1, 0);
    set_vec( 4, 0, 0, 1, 0, 246,   3, 1, 0);
    set_vec( 5, 0, 0, 0, 0, 246,   3, 1, 0);
    set_vec( 6, 1, 0, 0, 0, 246,   3, 1, 0);
    set_vec( 7, 0, 1, 1, 0, 234, -12, 1, 0);
    set_vec( 8, 0, 0, 1, 0, 223, -11, 1, 0);
    set_vec( 9, 0, 1, 0, 1, 223, -11, 0, 1);
    set_vec(10, 0, 1, 0, 0, 223, -11, 0, 1);
    set_vec(11, 0, 0, 1, 0, 223, -11, 0, 1);
    set_vec(12, 1, 0, 0, 0, 240,   0, 0, 0);
    set_vec(13, 1, 0, 0, 1, 240,   0, 1, 0);
    set_vec(14, 0, 0, 0, 1, 240,   0, 0, 1);
    set_vec(15, 1, 0, 0, 0, 240,   0, 0, 0);

    reset = 1'b1; start = 1'b0; up_key_press = 1'b0; down_key_press = 1'b0; hit = 1'b0;
    model_reset();
    #12;
    check("reset.y", int'(bird_y), 240);
    check("reset.vel", int'(bird_vel), 0);
    check("reset.playing", int'(playing), 0);
    check("reset.game_over", int'(game_over), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      drive_cycle(tbl[i].s, tbl[i].u, tbl[i].d, tbl[i].h);
      check($sformatf("vec%0d.y", i),   int'(bird_y),    tbl[i].y);
      check($sformatf("vec%0d.vel", i), int'(bird_vel),  tbl[i].v);
      check($sformatf("vec%0d.playing", i),   int'(playing),   int'(tbl[i].p));
      check($sformatf("vec%0d.game_over", i), int'(game_over), int'(tbl[i].g));
    end

    // Velocity saturation over 20 gravity ticks, then fall to the ground.
    drive_cycle(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive_cycle(0, 0, 1, 0);
      check_model($sformatf("sat%0d", i));
      check("sat.vel_le_15", (int'(bird_vel) > 15) ? 1 : 0, 0);
    end
    check("sat.final_vel", int'(bird_vel), 15);
    check("sat.final_y", int'(bird_y), 435);
    for (int k = 0; k < 10 && !game_over; k++) begin
      drive_cycle(0, 0, 1, 0);
      check_model($sformatf("fall%0d", k));
    end
    check("ground.game_over", int'(game_over), 1);
    check("ground.y", int'(bird_y), 464);
    check("ground.vel", int'(bird_vel), 0);

    // Back to idle, then flap into the ceiling.
    drive_cycle(1, 0, 0, 0);
    check_model("dead_to_idle");
    drive_cycle(1, 0, 0, 0);
    for (int i = 0; i < 21; i++) begin
      drive_cycle(0, 1, 0, 0);
      check_model($sformatf("flap%0d", i));
    end
    check("ceiling.y", int'(bird_y), 0);
    check("ceiling.vel", int'(bird_vel), 0);
    check("ceiling.playing", int'(playing), 1);

    // Asynchronous reset in the middle of a round, away from any clock edge.
    for (int i = 0; i < 12; i++) drive_cycle(0, 0, 1, 0);
    check("pre_reset.playing", int'(playing), 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset.y", int'(bird_y), 240);
    check("async_reset.vel", int'(bird_vel), 0);
    check("async_reset.playing", int'(playing), 0);
    check("async_reset.game_over", int'(game_over), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Random ticks, starts and hits against the model.
    for (int i = 0; i < 600; i++) begin
      drive_cycle($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
